// File: rtl/mac_pkg.sv
// Shared operand/product widths and FSM encoding for the 3x3 multiply-accumulate slice.
package mac_pkg;
  localparam int MUL_W  = 3;
  localparam int PROD_W = 6;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;
endpackage

// File: rtl/mul_3x3.sv
// Combinational 3x3 unsigned multiplier; zero latency, no flow control.
module mul_3x3
  import mac_pkg::*;
(
  input  logic [MUL_W-1:0]  a,
  input  logic [MUL_W-1:0]  b,
  output logic [PROD_W-1:0] prod
);

  assign prod = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_3x3_acc.sv
// Sums N_TERMS registered 3x3 products; result valid N_TERMS+1 cycles after first accept.
// Backpressure: result held and in_ready low until out_ready consumes it.
module mac_3x3_acc
  import mac_pkg::*;
#(
  parameter int N_TERMS = 4,
  parameter int ACC_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MUL_W-1:0] a,
  input  logic [MUL_W-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             ovf
);

  localparam int CNT_W = $clog2(N_TERMS + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_TERMS);

  state_t             state_q, state_d;
  logic [MUL_W-1:0]   op_a_q, op_a_d;
  logic [MUL_W-1:0]   op_b_q, op_b_d;
  logic               op_v_q, op_v_d;
  logic [CNT_W-1:0]   acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]   term_cnt_q, term_cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic [PROD_W-1:0]  prod;
  logic [ACC_W:0]     sum;
  logic               accept;

  mul_3x3 u_mul (
    .a    (op_a_q),
    .b    (op_b_q),
    .prod (prod)
  );

  assign accept = in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_v_d      = 1'b0;
    acc_cnt_d   = acc_cnt_q;
    term_cnt_d  = term_cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    sum         = {1'b0, acc_q} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod};

    if (accept) begin
      op_a_d    = a;
      op_b_d    = b;
      op_v_d    = 1'b1;
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end

    // The carry out of the widened sum is the overflow of this addition.
    if (op_v_q) begin
      acc_d      = sum[ACC_W-1:0];
      ovf_d      = ovf_q | sum[ACC_W];
      term_cnt_d = term_cnt_q + CNT_W'(1);
      if (term_cnt_d == N_CNT) begin
        state_d     = DONE;
        out_valid_d = 1'b1;
      end
    end

    if (state_q == DONE && out_valid_q && out_ready) begin
      state_d     = ACCUM;
      out_valid_d = 1'b0;
      acc_d       = '0;
      ovf_d       = 1'b0;
      acc_cnt_d   = '0;
      term_cnt_d  = '0;
      op_v_d      = 1'b0;
    end

    // Registered so in_ready never depends on in_valid within a cycle.
    in_ready_d = (state_d == ACCUM) && (acc_cnt_d < N_CNT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACCUM;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_v_q      <= 1'b0;
      acc_cnt_q   <= '0;
      term_cnt_q  <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_v_q      <= op_v_d;
      acc_cnt_q   <= acc_cnt_d;
      term_cnt_q  <= term_cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_mac_3x3_acc.sv
// Bench for mac_3x3_acc: default 8-bit and narrow 6-bit accumulator instances share one stimulus stream.
module tb_mac_3x3_acc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [2:0] a = '0;
  logic [2:0] b = '0;
  logic       out_ready = 1'b0;

  logic       in_ready, out_valid, ovf;
  logic [7:0] acc_out;
  logic       in_ready6, out_valid6, ovf6;
  logic [5:0] acc_out6;

  int n_vec = 0;
  int n_err = 0;

  mac_3x3_acc #(.N_TERMS(4), .ACC_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .acc_out(acc_out), .ovf(ovf)
  );

  mac_3x3_acc #(.N_TERMS(4), .ACC_W(6)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready6), .a(a), .b(b),
    .out_valid(out_valid6), .out_ready(out_ready), .acc_out(acc_out6), .ovf(ovf6)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] ta, input logic [2:0] tb);
    in_valid = v;
    a = ta;
    b = tb;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_vec++; if (acc_out !== 8'd0) begin n_err++; $display("FAIL rst_acc got %0d exp 0", acc_out); end
    n_vec++; if (ovf !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %b exp 0", ovf); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_err++; $display("FAIL post_rst_hs got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid); end
  endtask

  task automatic test_max_products;
    int sum = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL max_rdy%0d got %b exp 1", i, in_ready); end
      drive(1'b1, 3'd7, 3'd7);
      sum += 49;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL max_early_vld%0d got %b exp 0", i, out_valid); end
    end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL max_rdy_drop got %b exp 0", in_ready); end
    drive(1'b1, 3'd7, 3'd7);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL max_vld got %b exp 1", out_valid); end
    n_vec++; if (acc_out !== 8'(sum)) begin n_err++; $display("FAIL max_acc got %0d exp %0d", acc_out, 8'(sum)); end
    n_vec++; if (ovf !== (sum >= 256)) begin n_err++; $display("FAIL max_ovf got %b exp %b", ovf, (sum >= 256)); end
    n_vec++; if (acc_out6 !== 6'(sum) || ovf6 !== (sum >= 64)) begin n_err++; $display("FAIL max_acc6 got %0d/%b exp %0d/%b", acc_out6, ovf6, 6'(sum), (sum >= 64)); end
    drive(1'b1, 3'd7, 3'd7);
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL max_turn got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    n_vec++; if (acc_out !== 8'd0) begin n_err++; $display("FAIL max_clear got %0d exp 0", acc_out); end
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 3'd0);
    n_vec++; if (acc_out !== 8'd0) begin n_err++; $display("FAIL max_no_hs_accept got %0d exp 0", acc_out); end
  endtask

  task automatic test_mixed;
    int pa[4] = '{3, 0, 6, 1};
    int pb[4] = '{5, 7, 2, 1};
    int sum = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'(pa[i]), 3'(pb[i]));
      sum += pa[i] * pb[i];
    end
    drive(1'b0, 3'd0, 3'd0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mixed_vld got %b exp 1", out_valid); end
    n_vec++; if (acc_out !== 8'(sum) || ovf !== 1'b0) begin n_err++; $display("FAIL mixed_acc got %0d/%b exp %0d/0", acc_out, ovf, 8'(sum)); end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_overflow;
    int pa[4] = '{7, 7, 1, 0};
    int pb[4] = '{7, 7, 1, 0};
    int tot = 0;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) drive(1'b1, 3'(pa[k]), 3'(pb[k]));
      else       drive(1'b0, 3'd0, 3'd0);
      if (k > 0) tot += pa[k-1] * pb[k-1];
      n_vec++; if (acc_out6 !== 6'(tot) || ovf6 !== (tot >= 64)) begin n_err++; $display("FAIL ovf_step%0d got %0d/%b exp %0d/%b", k, acc_out6, ovf6, 6'(tot), (tot >= 64)); end
      n_vec++; if (acc_out !== 8'(tot)) begin n_err++; $display("FAIL ovf_wide_step%0d got %0d exp %0d", k, acc_out, 8'(tot)); end
    end
    n_vec++; if (out_valid6 !== 1'b1) begin n_err++; $display("FAIL ovf_vld got %b exp 1", out_valid6); end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
    n_vec++; if (out_valid6 !== 1'b0 || ovf6 !== 1'b0 || acc_out6 !== 6'd0 || in_ready6 !== 1'b1) begin
      n_err++; $display("FAIL ovf_clear got vld=%b ovf=%b acc=%0d rdy=%b exp 0/0/0/1", out_valid6, ovf6, acc_out6, in_ready6);
    end
  endtask

  task automatic test_backpressure;
    int sum = 0;
    logic [2:0] ta, tb;
    for (int i = 0; i < 4; i++) begin
      ta = 3'($urandom_range(0, 7));
      tb = 3'($urandom_range(0, 7));
      drive(1'b1, ta, tb);
      sum += int'(ta) * int'(tb);
    end
    drive(1'b0, 3'd0, 3'd0);
    for (int c = 0; c < 5; c++) begin
      drive(1'($urandom_range(0, 1)), 3'd7, 3'd7);
      n_vec++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hs%0d got vld=%b rdy=%b exp vld=1 rdy=0", c, out_valid, in_ready); end
      n_vec++; if (acc_out !== 8'(sum) || ovf !== (sum >= 256)) begin n_err++; $display("FAIL bp_hold%0d got %0d/%b exp %0d/%b", c, acc_out, ovf, 8'(sum), (sum >= 256)); end
      n_vec++; if (acc_out6 !== 6'(sum) || ovf6 !== (sum >= 64)) begin n_err++; $display("FAIL bp_hold6_%0d got %0d/%b exp %0d/%b", c, acc_out6, ovf6, 6'(sum), (sum >= 64)); end
    end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready); end
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd2, 3'd2);
      sum += 4;
    end
    drive(1'b0, 3'd0, 3'd0);
    n_vec++; if (out_valid !== 1'b1 || acc_out !== 8'(sum)) begin n_err++; $display("FAIL bp_next got vld=%b acc=%0d exp vld=1 acc=%0d", out_valid, acc_out, 8'(sum)); end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_bubbles;
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int sum = 0;
    for (int i = 0; i < 7; i++) begin
      drive(pat[i], 3'd2, 3'd3);
      if (pat[i]) sum += 6;
    end
    n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL bub_pending got rdy=%b vld=%b exp rdy=0 vld=0", in_ready, out_valid); end
    drive(1'b0, 3'd0, 3'd0);
    n_vec++; if (out_valid !== 1'b1 || acc_out !== 8'(sum)) begin n_err++; $display("FAIL bub_acc got vld=%b acc=%0d exp vld=1 acc=%0d", out_valid, acc_out, 8'(sum)); end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int sum = 0;
    drive(1'b1, 3'd7, 3'd7);
    drive(1'b1, 3'd7, 3'd7);
    n_vec++; if (acc_out !== 8'd49) begin n_err++; $display("FAIL rmid_partial got %0d exp 49", acc_out); end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0 || acc_out !== 8'd0 || in_ready !== 1'b1 || acc_out6 !== 6'd0) begin
      n_err++; $display("FAIL rmid_async got vld=%b acc=%0d rdy=%b acc6=%0d exp 0/0/1/0", out_valid, acc_out, in_ready, acc_out6);
    end
    #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'd1, 3'd2);
      sum += 2;
    end
    drive(1'b0, 3'd0, 3'd0);
    n_vec++; if (out_valid !== 1'b1 || acc_out !== 8'(sum)) begin n_err++; $display("FAIL rmid_fresh got vld=%b acc=%0d exp vld=1 acc=%0d", out_valid, acc_out, 8'(sum)); end
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0);
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0] ta, tb;
    logic v;
    int sum, taken, hold;
    for (int r = 0; r < 6; r++) begin
      sum = 0;
      taken = 0;
      while (taken < 4) begin
        v  = ($urandom_range(0, 2) != 0);
        ta = 3'($urandom_range(0, 7));
        tb = 3'($urandom_range(0, 7));
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd%0d_rdy got %b exp 1", r, in_ready); end
        drive(v, ta, tb);
        if (v) begin
          sum += int'(ta) * int'(tb);
          taken++;
        end
      end
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rnd%0d_pend got rdy=%b vld=%b exp 0/0", r, in_ready, out_valid); end
      drive(1'b0, 3'd0, 3'd0);
      n_vec++; if (out_valid !== 1'b1 || acc_out !== 8'(sum) || ovf !== (sum >= 256)) begin
        n_err++; $display("FAIL rnd%0d_res got vld=%b acc=%0d ovf=%b exp 1/%0d/%b", r, out_valid, acc_out, ovf, 8'(sum), (sum >= 256));
      end
      n_vec++; if (acc_out6 !== 6'(sum) || ovf6 !== (sum >= 64)) begin n_err++; $display("FAIL rnd%0d_res6 got %0d/%b exp %0d/%b", r, acc_out6, ovf6, 6'(sum), (sum >= 64)); end
      hold = $urandom_range(0, 3);
      for (int c = 0; c < hold; c++) begin
        drive(1'($urandom_range(0, 1)), 3'd5, 3'd5);
        n_vec++; if (out_valid !== 1'b1 || acc_out !== 8'(sum) || in_ready !== 1'b0) begin
          n_err++; $display("FAIL rnd%0d_hold got vld=%b acc=%0d rdy=%b exp 1/%0d/0", r, out_valid, acc_out, in_ready, 8'(sum));
        end
      end
      out_ready = 1'b1;
      drive(1'b0, 3'd0, 3'd0);
      out_ready = 1'b0;
      n_vec++; if (out_valid !== 1'b0 || acc_out !== 8'd0 || ovf !== 1'b0) begin n_err++; $display("FAIL rnd%0d_clr got vld=%b acc=%0d ovf=%b exp 0/0/0", r, out_valid, acc_out, ovf); end
    end
  endtask

  initial begin
    test_reset();
    test_max_products();
    test_mixed();
    test_overflow();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
